// File: rtl/snake_state_engine.sv
// snake_state_engine
// Game-state engine for the player-1 snake on a 40x40 board. It samples the
// direction buttons, moves the snake once every FRAMES_PER_MOVE video frames,
// grows it on the fixed apple, detects wall hits and runs the stage FSM
// (IDLE=0, PLAY=2, OVER=3). Snake 2 is parked: static head, length 0.
//
// Ports
//   iVGA_CLK          in   1    pixel clock, all logic on rising edge
//   iRST_n            in   1    asynchronous active-low reset
//   iVS               in   1    vertical sync, active-low (falling edge = frame tick)
//   iStart            in   1    start/acknowledge button, active-high, async
//   up/down/left/right in  1    direction buttons, active-high, async
//   oSnake_data       out  424  packed state bus read by the VGA controller
//   oMove             out  1    one-cycle pulse when oSnake_data updates from a move
//
// Bus layout: [199:0] dir ring (entry k at [2k+1:2k], 0..49 snake 1, 50..99 snake 2),
// [231:200] head1, [263:232] head2, [295:264] length1, [327:296] length2,
// [359:328] stage, [391:360] head1 ring index (0), [423:392] head2 ring index (50).
module snake_state_engine #(
  parameter int unsigned FRAMES_PER_MOVE = 6,
  parameter int unsigned START_POS       = 820,
  parameter int unsigned START_LEN       = 3,
  parameter int unsigned MAX_LEN         = 49,
  parameter int unsigned APPLE_POS       = 425,
  parameter int unsigned SNAKE2_POS      = 1560
) (
  input  logic         iVGA_CLK,
  input  logic         iRST_n,
  input  logic         iVS,
  input  logic         iStart,
  input  logic         up,
  input  logic         down,
  input  logic         left,
  input  logic         right,
  output logic [423:0] oSnake_data,
  output logic         oMove
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd2,
    S_OVER = 2'd3
  } stage_e;

  // Dir codes double as the ring encoding: step toward the next older segment.
  typedef enum logic [1:0] {
    D_UP    = 2'd0,
    D_RIGHT = 2'd1,
    D_DOWN  = 2'd2,
    D_LEFT  = 2'd3
  } dir_e;

  localparam logic [10:0] START_HEAD = 11'(START_POS);
  localparam logic [5:0]  START_ROW  = 6'(START_POS / 40);
  localparam logic [5:0]  START_COL  = 6'(START_POS % 40);

  // Synchronizers: bit order {iStart, up, down, left, right}.
  logic [4:0]  btn_s1_q, btn_s2_q;
  logic        start_prev_q;
  logic        vs_s1_q, vs_s2_q, vs_prev_q;

  stage_e      stage_q;
  dir_e        cmt_q, pend_q;
  logic [10:0] head_q;
  logic [5:0]  row_q, col_q;
  logic [5:0]  len_q;
  logic [99:0] ring_q;
  logic [7:0]  cnt_q;
  logic        move_pend_q;

  logic        start_rise, vs_fall;
  logic        btn_valid;
  dir_e        btn_dir;
  logic        hit_wall;
  logic [10:0] head_d;
  logic [5:0]  row_d, col_d;

  assign start_rise = btn_s2_q[4] & ~start_prev_q;
  assign vs_fall    = ~vs_s2_q & vs_prev_q;

  // Highest-priority button wins; a reversal of the committed direction is dropped
  // outright rather than falling through to a lower-priority button.
  always_comb begin
    btn_valid = 1'b0;
    btn_dir   = D_RIGHT;
    if (btn_s2_q[3]) begin
      btn_dir = D_UP;    btn_valid = 1'b1;
    end else if (btn_s2_q[2]) begin
      btn_dir = D_DOWN;  btn_valid = 1'b1;
    end else if (btn_s2_q[1]) begin
      btn_dir = D_LEFT;  btn_valid = 1'b1;
    end else if (btn_s2_q[0]) begin
      btn_dir = D_RIGHT; btn_valid = 1'b1;
    end
    if (btn_valid && (btn_dir == dir_e'(cmt_q ^ 2'b10))) btn_valid = 1'b0;
  end

  // Next head uses the pending dir, which becomes committed on the move cycle.
  always_comb begin
    hit_wall = 1'b0;
    head_d   = head_q;
    row_d    = row_q;
    col_d    = col_q;
    case (pend_q)
      D_UP: begin
        hit_wall = (row_q == 6'd0);
        head_d   = head_q - 11'd40;
        row_d    = row_q - 6'd1;
      end
      D_DOWN: begin
        hit_wall = (row_q == 6'd39);
        head_d   = head_q + 11'd40;
        row_d    = row_q + 6'd1;
      end
      D_LEFT: begin
        hit_wall = (col_q == 6'd0);
        head_d   = head_q - 11'd1;
        col_d    = col_q - 6'd1;
      end
      default: begin
        hit_wall = (col_q == 6'd39);
        head_d   = head_q + 11'd1;
        col_d    = col_q + 6'd1;
      end
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      btn_s1_q     <= '0;
      btn_s2_q     <= '0;
      start_prev_q <= 1'b0;
      vs_s1_q      <= 1'b1;
      vs_s2_q      <= 1'b1;
      vs_prev_q    <= 1'b1;
      stage_q      <= S_IDLE;
      cmt_q        <= D_RIGHT;
      pend_q       <= D_RIGHT;
      head_q       <= START_HEAD;
      row_q        <= START_ROW;
      col_q        <= START_COL;
      len_q        <= 6'(START_LEN);
      ring_q       <= '1;
      cnt_q        <= '0;
      move_pend_q  <= 1'b0;
      oMove        <= 1'b0;
    end else begin
      btn_s1_q     <= {iStart, up, down, left, right};
      btn_s2_q     <= btn_s1_q;
      start_prev_q <= btn_s2_q[4];
      vs_s1_q      <= iVS;
      vs_s2_q      <= vs_s1_q;
      vs_prev_q    <= vs_s2_q;
      oMove        <= 1'b0;
      move_pend_q  <= 1'b0;
      case (stage_q)
        S_IDLE: begin
          if (start_rise) begin
            stage_q <= S_PLAY;
            cmt_q   <= D_RIGHT;
            pend_q  <= D_RIGHT;
            head_q  <= START_HEAD;
            row_q   <= START_ROW;
            col_q   <= START_COL;
            len_q   <= 6'(START_LEN);
            ring_q  <= '1;
            cnt_q   <= '0;
          end
        end
        S_PLAY: begin
          if (btn_valid) pend_q <= btn_dir;
          if (vs_fall) begin
            if (cnt_q == 8'(FRAMES_PER_MOVE - 1)) begin
              cnt_q       <= '0;
              move_pend_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          if (move_pend_q) begin
            if (hit_wall) begin
              stage_q <= S_OVER;
            end else begin
              cmt_q  <= pend_q;
              head_q <= head_d;
              row_q  <= row_d;
              col_q  <= col_d;
              // Newest entry points back toward the old head: the reverse of the move.
              ring_q <= {ring_q[97:0], pend_q ^ 2'b10};
              oMove  <= 1'b1;
              if ((head_d == 11'(APPLE_POS)) && (len_q < 6'(MAX_LEN))) len_q <= len_q + 6'd1;
            end
          end
        end
        S_OVER: begin
          if (start_rise) stage_q <= S_IDLE;
        end
        default: stage_q <= S_IDLE;
      endcase
    end
  end

  assign oSnake_data = {32'd50, 32'd0, {30'd0, stage_q}, 32'd0, {26'd0, len_q},
                        32'(SNAKE2_POS), {21'd0, head_q}, 100'd0, ring_q};

endmodule
